button_conditioner: RTL
=======================

# button_conditioner

Parametrised multi-channel push-button front end. Each of `N_CH` raw button inputs is synchronised, debounced on an internal sample tick, and decoded into press, release, short-press, long-press and auto-repeat pulses that are one `clk` cycle wide. All logic runs on the single system clock, so no derived clocks leave the block. It sits between the board push-buttons and the lab FSMs, replacing per-button debounce, one-pulse and long-press glue.

## Interface
- `N_CH`, 3: number of independent button channels (≥1).
- `CLK_DIV`, 1000000: `clk` cycles per sample tick (≥2).
- `DB_SAMPLES`, 4: consecutive equal samples required to change the debounced level (≥2).
- `LONG_TICKS`, 100: ticks the button must be held before `long_pulse` fires (≥1).
- `REPEAT_TICKS`, 20: ticks between `repeat_pulse`s after a long press; 0 disables repeat.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `pb_in`  in  N_CH  raw asynchronous button levels, 1 = pressed.
- `level`  out  N_CH  debounced button level.
- `press_pulse`  out  N_CH  1-cycle pulse on debounced rise.
- `release_pulse`  out  N_CH  1-cycle pulse on debounced fall.
- `short_pulse`  out  N_CH  1-cycle pulse on release before the long threshold.
- `long_pulse`  out  N_CH  1-cycle pulse when the hold reaches `LONG_TICKS`.
- `repeat_pulse`  out  N_CH  1-cycle pulse every `REPEAT_TICKS` while held after a long press.

## Operation
- Prescaler: counter 0..CLK_DIV-1, shared by all channels. `tick` is high for one `clk` when the counter equals CLK_DIV-1, then the counter wraps to 0.
- Per channel: a 2-flop synchroniser feeds a `DB_SAMPLES`-bit sample shift register that shifts only on `tick`.
  - When the register is all ones, `level` is set to 1.
  - When it is all zeros, `level` is cleared to 0.
  - Otherwise `level` holds.
  - `level` updates on the tick edge.
- Edge detect: `press_pulse`/`release_pulse` are registered and asserted in the `clk` cycle after `level` changes.
- Per-channel FSM, states IDLE, PRESSED, HELD. The hold counter is `$clog2(max(LONG_TICKS,REPEAT_TICKS)+1)` bits and saturates, never wraps.
  - IDLE: on `level` rise → PRESSED, hold counter = 0.
  - PRESSED: on `tick` with `level`=1, counter += 1. When it reaches LONG_TICKS → assert `long_pulse`, enter HELD, counter = 0. On `level`=0 → assert `short_pulse`, go to IDLE.
  - HELD: if REPEAT_TICKS>0, counter += 1 on each `tick`. When it reaches REPEAT_TICKS → assert `repeat_pulse`, counter = 0. On `level`=0 → IDLE with no `short_pulse`.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- Reset values:
  - All outputs are 0.
  - The prescaler, sample registers, synchronisers and hold counters are 0.
  - All FSMs are in IDLE.
- Reset mid-press: a button held through `rst` is reported as a new press. After `rst` deasserts, `press_pulse` fires once the register fills with ones.
- Press latency: 2 sync cycles plus DB_SAMPLES ticks, then 1 cycle. The bound is at most 3 + DB_SAMPLES·CLK_DIV `clk` cycles from the `pb_in` edge to `press_pulse`. Release latency follows the same rule.
- `short_pulse` and `release_pulse` are asserted in the same cycle.
- `long_pulse` fires in the cycle after the tick at which the counter reaches LONG_TICKS.
  - If `level` falls on that same tick edge, `long_pulse` still fires.
  - `release_pulse` follows 1 cycle later, and no `short_pulse` is generated.
- Glitches shorter than DB_SAMPLES consecutive samples never change `level` and never produce pulses.
- Every pulse output is exactly one `clk` wide and never asserts on two consecutive cycles for the same event.

## Test plan
All scenarios use N_CH=2, CLK_DIV=4, DB_SAMPLES=3, LONG_TICKS=5, REPEAT_TICKS=2.
- Reset: apply `rst` for 3 cycles with `pb_in`=2'b11. All outputs are 0 during reset. `press_pulse`=2'b11 arrives in a single cycle within 15 cycles after `rst` drops.
- Short press: ch0 high for 3 ticks, then low. Expect `press_pulse[0]`, then `short_pulse[0]` and `release_pulse[0]` in the same cycle, with no `long_pulse`.
- Long press with repeat: ch1 held for 12 ticks. Expect:
  - `long_pulse[1]` once, 5 ticks after `level[1]` rises.
  - `repeat_pulse[1]` every 8 `clk` cycles.
  - On release, `release_pulse[1]` only.
- Glitch rejection: ch0 high for exactly 2 ticks. `level[0]` stays 0 and no pulses occur.
- Long/release coincidence: release ch0 so that `level` falls on the tick where the count reaches 5. Expect `long_pulse[0]`, then `release_pulse[0]` the next cycle, and no `short_pulse`.
- Independence: stagger a ch0 short press and a ch1 long press so they overlap. Each channel's pulses match its solo run, and same-cycle pulses on both channels appear together.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button front end.
// Each raw button is synchronised, debounced on a shared sample tick and
// decoded into one-clk-wide press/release/short/long/repeat pulses.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   pb_in          raw asynchronous button levels, 1 = pressed
//   level          debounced button level
//   press_pulse    1-cycle pulse on debounced rise
//   release_pulse  1-cycle pulse on debounced fall
//   short_pulse    1-cycle pulse on release before the long threshold
//   long_pulse     1-cycle pulse when the hold reaches LONG_TICKS
//   repeat_pulse   1-cycle pulse every REPEAT_TICKS while held after long
module button_conditioner #(
  parameter int unsigned N_CH         = 3,
  parameter int unsigned CLK_DIV      = 1000000,
  parameter int unsigned DB_SAMPLES   = 4,
  parameter int unsigned LONG_TICKS   = 100,
  parameter int unsigned REPEAT_TICKS = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] short_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam int unsigned DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] LONG_CNT = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] REP_CNT  = HOLD_W'(REPEAT_TICKS);
  localparam logic              REP_EN   = (REPEAT_TICKS != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic [N_CH-1:0]       sync1, sync2;
  logic [DB_SAMPLES-1:0] samp    [N_CH];
  logic [DB_SAMPLES-1:0] samp_nx [N_CH];
  logic [N_CH-1:0]       level_d;
  logic [N_CH-1:0]       rise;

  state_t                state_q  [N_CH];
  state_t                state_nx [N_CH];
  logic [HOLD_W-1:0]     hold_q   [N_CH];
  logic [HOLD_W-1:0]     hold_nx  [N_CH];
  logic [HOLD_W-1:0]     hold_inc [N_CH];
  logic [N_CH-1:0]       long_nx, short_nx, rep_nx;

  // Shared sample-tick prescaler
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  always_comb begin
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      samp_nx[ch] = {samp[ch][DB_SAMPLES-2:0], sync2[ch]};
    end
  end

  // Level is decided from the post-shift sample vector so that it moves on
  // the same tick edge that completes the run of equal samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      for (int unsigned ch = 0; ch < N_CH; ch++) samp[ch] <= '0;
    end else begin
      sync1 <= pb_in;
      sync2 <= sync1;
      if (tick) begin
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
          samp[ch] <= samp_nx[ch];
          if (&samp_nx[ch])       level[ch] <= 1'b1;
          else if (~|samp_nx[ch]) level[ch] <= 1'b0;
        end
      end
    end
  end

  assign rise = level & ~level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_d       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      level_d       <= level;
      press_pulse   <= rise;
      release_pulse <= ~level & level_d;
    end
  end

  // Saturating hold counter increment
  always_comb begin
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      hold_inc[ch] = (&hold_q[ch]) ? hold_q[ch] : hold_q[ch] + 1'b1;
    end
  end

  // Level drop has priority over tick counting, so a fall on the threshold
  // tick edge is only seen one cycle later: long fires, short does not.
  always_comb begin
    long_nx  = '0;
    short_nx = '0;
    rep_nx   = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      state_nx[ch] = state_q[ch];
      hold_nx[ch]  = hold_q[ch];
      case (state_q[ch])
        IDLE: begin
          if (rise[ch]) begin
            state_nx[ch] = PRESSED;
            hold_nx[ch]  = '0;
          end
        end
        PRESSED: begin
          if (!level[ch]) begin
            short_nx[ch] = 1'b1;
            state_nx[ch] = IDLE;
          end else if (tick) begin
            if (hold_inc[ch] == LONG_CNT) begin
              long_nx[ch]  = 1'b1;
              state_nx[ch] = HELD;
              hold_nx[ch]  = '0;
            end else begin
              hold_nx[ch]  = hold_inc[ch];
            end
          end
        end
        HELD: begin
          if (!level[ch]) begin
            state_nx[ch] = IDLE;
          end else if (REP_EN && tick) begin
            if (hold_inc[ch] == REP_CNT) begin
              rep_nx[ch]  = 1'b1;
              hold_nx[ch] = '0;
            end else begin
              hold_nx[ch] = hold_inc[ch];
            end
          end
        end
        default: state_nx[ch] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      short_pulse  <= '0;
      long_pulse   <= '0;
      repeat_pulse <= '0;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        state_q[ch] <= IDLE;
        hold_q[ch]  <= '0;
      end
    end else begin
      short_pulse  <= short_nx;
      long_pulse   <= long_nx;
      repeat_pulse <= rep_nx;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        state_q[ch] <= state_nx[ch];
        hold_q[ch]  <= hold_nx[ch];
      end
    end
  end

endmodule
